// File: rtl/craps_game_ctrl.sv
// -----------------------------------------------------------------------------
// craps_game_ctrl
//   Game sequencer for a two-dice craps table. Accepts roll strobes from the
//   dice source, classifies the sum against the come-out / point rules, and
//   keeps the point, last sum, per-game roll count and win/loss tallies for
//   the display logic. Every output is a register; a roll's effect shows up
//   on the same rising edge that samples roll_valid.
// -----------------------------------------------------------------------------
module craps_game_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             roll_valid,
  input  logic [2:0]       die1,
  input  logic [2:0]       die2,
  input  logic             new_game,
  output logic [1:0]       state,
  output logic [3:0]       point,
  output logic [3:0]       last_sum,
  output logic             game_over,
  output logic             bad_roll,
  output logic [CNT_W-1:0] roll_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  // Encodings are visible on the state port, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // come-out roll pending
    ST_POINT = 2'b01,  // point established, rolling for point or seven
    ST_WIN   = 2'b10,
    ST_LOSE  = 2'b11
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [3:0]       r_point;
  logic [3:0]       r_last_sum;
  logic             r_game_over;
  logic             r_bad_roll;
  logic [CNT_W-1:0] r_roll_cnt;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  // ---------------------------------------------------------------------------
  // Roll qualification
  // ---------------------------------------------------------------------------
  logic       w_die1_ok;
  logic       w_die2_ok;
  logic [3:0] w_sum;
  logic       w_in_play;
  logic       w_roll_req;
  logic       w_accept;
  logic       w_bad;

  // A 3-bit die can only be out of range as 0 or 7.
  assign w_die1_ok  = (die1 != 3'd0) && (die1 != 3'd7);
  assign w_die2_ok  = (die2 != 3'd0) && (die2 != 3'd7);
  assign w_sum      = {1'b0, die1} + {1'b0, die2};

  // Rolls only matter while a game is in progress; a simultaneous new_game
  // swallows the roll, including any illegal-die report.
  assign w_in_play  = (r_state == ST_IDLE) || (r_state == ST_POINT);
  assign w_roll_req = roll_valid && !new_game && w_in_play;
  assign w_accept   = w_roll_req && w_die1_ok && w_die2_ok;
  assign w_bad      = w_roll_req && !(w_die1_ok && w_die2_ok);

  // ---------------------------------------------------------------------------
  // Sum classification
  // ---------------------------------------------------------------------------
  state_t w_next_state;
  logic   w_set_point;
  logic   w_win_entry;
  logic   w_lose_entry;

  // Decide where an accepted roll takes the game.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_set_point  = 1'b0;
    w_win_entry  = 1'b0;
    w_lose_entry = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        ST_IDLE: begin
          unique case (w_sum)
            4'd7, 4'd11: begin
              w_next_state = ST_WIN;
              w_win_entry  = 1'b1;
            end
            4'd2, 4'd3, 4'd12: begin
              w_next_state = ST_LOSE;
              w_lose_entry = 1'b1;
            end
            // Legal dice leave only 4, 5, 6, 8, 9 and 10 here.
            default: begin
              w_next_state = ST_POINT;
              w_set_point  = 1'b1;
            end
          endcase
        end
        ST_POINT: begin
          // The point is never 7, so the two tests cannot both hit.
          if (w_sum == r_point) begin
            w_next_state = ST_WIN;
            w_win_entry  = 1'b1;
          end else if (w_sum == 4'd7) begin
            w_next_state = ST_LOSE;
            w_lose_entry = 1'b1;
          end
        end
        default: begin
          // WIN/LOSE never accept a roll; they wait for new_game.
          w_next_state = r_state;
        end
      endcase
    end
  end

  // Game FSM with all status outputs registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_point     <= 4'd0;
      r_last_sum  <= 4'd0;
      r_game_over <= 1'b0;
      r_bad_roll  <= 1'b0;
      r_roll_cnt  <= '0;
      r_win_cnt   <= '0;
      r_loss_cnt  <= '0;
    end else begin
      // Both flags are single-cycle pulses unless re-armed below.
      r_game_over <= 1'b0;
      r_bad_roll  <= w_bad;

      if (new_game) begin
        // Abandon or clear: last_sum and the tallies stay for display.
        r_state    <= ST_IDLE;
        r_point    <= 4'd0;
        r_roll_cnt <= '0;
      end else if (w_accept) begin
        r_state    <= w_next_state;
        r_last_sum <= w_sum;
        r_roll_cnt <= sat_inc(r_roll_cnt);
        if (w_set_point) begin
          r_point <= w_sum;
        end
        if (w_win_entry) begin
          r_win_cnt   <= sat_inc(r_win_cnt);
          r_game_over <= 1'b1;
        end
        if (w_lose_entry) begin
          r_loss_cnt  <= sat_inc(r_loss_cnt);
          r_game_over <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state     = r_state;
  assign point     = r_point;
  assign last_sum  = r_last_sum;
  assign game_over = r_game_over;
  assign bad_roll  = r_bad_roll;
  assign roll_cnt  = r_roll_cnt;
  assign win_cnt   = r_win_cnt;
  assign loss_cnt  = r_loss_cnt;

endmodule
